// File: rtl/btb_array_if.sv
// btb_array_if: fetch lookup, resolution fill/invalidate and perf counter bundle for btb_array
//   read_en/read_pc -> read_hit/read_entry      combinational IF-stage lookup
//   write_en/write_pc/write_entry               install or update from branch resolution
//   inval_en/inval_pc                           drop a stale prediction
//   lookup_count/hit_count                      saturating performance counters
//   master: requester side, slave: btb_array side
interface btb_array_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 read_en;
    logic [31:0]          read_pc;
    logic                 read_hit;
    logic [33:0]          read_entry;
    logic                 write_en;
    logic [31:0]          write_pc;
    logic [33:0]          write_entry;
    logic                 inval_en;
    logic [31:0]          inval_pc;
    logic [CNT_WIDTH-1:0] lookup_count;
    logic [CNT_WIDTH-1:0] hit_count;
    modport master (
        output read_en, read_pc, write_en, write_pc, write_entry, inval_en, inval_pc,
        input  read_hit, read_entry, lookup_count, hit_count
    );
    modport slave (
        input  read_en, read_pc, write_en, write_pc, write_entry, inval_en, inval_pc,
        output read_hit, read_entry, lookup_count, hit_count
    );
endinterface

// File: rtl/btb_array.sv
// btb_array: 2-way set-associative branch target buffer with combinational lookup and saturating perf counters
//   clk     clock, all state changes on posedge
//   rst     synchronous active-low reset
//   io_btb  btb_array_if.slave: lookup, fill, invalidate and counter signals
module btb_array #(
    parameter int S_INDEX   = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    btb_array_if.slave io_btb
);
    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 30 - S_INDEX;
    logic [1:0]           r_valid [SETS];
    logic [TAG_W-1:0]     r_tag   [SETS][2];
    logic [33:0]          r_entry [SETS][2];
    logic [SETS-1:0]      r_lru;
    logic [CNT_WIDTH-1:0] r_lookup;
    logic [CNT_WIDTH-1:0] r_hits;
    logic [S_INDEX-1:0]   w_ridx, w_widx, w_iidx;
    logic [TAG_W-1:0]     w_rtag, w_wtag, w_itag;
    logic [1:0]           w_rmatch, w_imatch, w_wvalid, w_wmatch;
    logic                 w_rway, w_iway, w_wway, w_read_hit, w_ihit, w_wdo;
    logic                 w_unused;
    assign w_ridx = io_btb.read_pc[S_INDEX+1:2];
    assign w_widx = io_btb.write_pc[S_INDEX+1:2];
    assign w_iidx = io_btb.inval_pc[S_INDEX+1:2];
    assign w_rtag = io_btb.read_pc[31:S_INDEX+2];
    assign w_wtag = io_btb.write_pc[31:S_INDEX+2];
    assign w_itag = io_btb.inval_pc[31:S_INDEX+2];
    assign w_unused = &{io_btb.read_pc[1:0], io_btb.write_pc[1:0], io_btb.inval_pc[1:0]};
    assign w_rmatch = r_valid[w_ridx] & {r_tag[w_ridx][1] == w_rtag, r_tag[w_ridx][0] == w_rtag};
    assign w_imatch = r_valid[w_iidx] & {r_tag[w_iidx][1] == w_itag, r_tag[w_iidx][0] == w_itag};
    // way0 wins whenever it matches
    assign w_rway     = ~w_rmatch[0];
    assign w_iway     = ~w_imatch[0];
    assign w_read_hit = io_btb.read_en && |w_rmatch;
    assign w_ihit     = io_btb.inval_en && |w_imatch;
    assign io_btb.read_hit   = w_read_hit;
    assign io_btb.read_entry = w_read_hit ? r_entry[w_ridx][w_rway] : '0;
    // an invalidate of the very line being written cancels the write
    assign w_wdo = io_btb.write_en && !(io_btb.inval_en && w_iidx == w_widx && w_itag == w_wtag);
    // write way choice sees the valid bits after this cycle's invalidate
    assign w_wvalid = r_valid[w_widx] & ~((w_ihit && w_iidx == w_widx) ? (2'b01 << w_iway) : 2'b00);
    assign w_wmatch = w_wvalid & {r_tag[w_widx][1] == w_wtag, r_tag[w_widx][0] == w_wtag};
    assign w_wway   = |w_wmatch ? ~w_wmatch[0] : (w_wvalid != 2'b11) ? w_wvalid[0] : r_lru[w_widx];
    assign io_btb.lookup_count = r_lookup;
    assign io_btb.hit_count    = r_hits;
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) r_valid[s] <= 2'b00;
            r_lru    <= '0;
            r_lookup <= '0;
            r_hits   <= '0;
        end else begin
            if (io_btb.read_en) assert (w_rmatch != 2'b11);
            // later assignments take priority: inval > write > read-hit for lru
            if (w_read_hit) r_lru[w_ridx] <= ~w_rway;
            if (w_ihit) r_valid[w_iidx][w_iway] <= 1'b0;
            if (w_wdo) begin
                r_valid[w_widx][w_wway] <= 1'b1;
                r_tag[w_widx][w_wway]   <= w_wtag;
                r_entry[w_widx][w_wway] <= io_btb.write_entry;
                r_lru[w_widx]           <= ~w_wway;
            end
            if (w_ihit) r_lru[w_iidx] <= w_iway;
            r_lookup <= r_lookup + CNT_WIDTH'(io_btb.read_en && !(&r_lookup));
            r_hits   <= r_hits + CNT_WIDTH'(w_read_hit && !(&r_hits));
        end
    end
endmodule

// File: tb/tb_btb_array.sv
// tb_btb_array: directed and randomized checks of btb_array against a behavioural reference model
module tb_btb_array;
    localparam logic [1:0] BR = 2'd1, JAL = 2'd2, JALR = 2'd3;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    btb_array_if #(.CNT_WIDTH(32)) bus ();
    btb_array_if #(.CNT_WIDTH(4))  bus4 ();
    assign bus4.read_en     = bus.read_en;
    assign bus4.read_pc     = bus.read_pc;
    assign bus4.write_en    = bus.write_en;
    assign bus4.write_pc    = bus.write_pc;
    assign bus4.write_entry = bus.write_entry;
    assign bus4.inval_en    = bus.inval_en;
    assign bus4.inval_pc    = bus.inval_pc;
    btb_array #(.S_INDEX(4), .CNT_WIDTH(32)) u_dut  (.clk(clk), .rst(rst), .io_btb(bus.slave));
    btb_array #(.S_INDEX(4), .CNT_WIDTH(4))  u_dut4 (.clk(clk), .rst(rst), .io_btb(bus4.slave));
    int passed = 0;
    int total  = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    // reference model: 16 sets, each holding two {valid, tag, entry} slots and a victim pointer
    bit          mv [16][2];
    logic [25:0] mt [16][2];
    logic [33:0] me [16][2];
    bit          ml [16];
    longint      lc, hc, lc4, hc4;
    bit          armed = 0;
    function automatic void mlook(input logic [31:0] pc, output bit hit, output bit way, output logic [33:0] e);
        int s;
        s = int'(pc[5:2]);
        hit = 0; way = 0; e = '0;
        for (int w = 1; w >= 0; w--)
            if (mv[s][w] && mt[s][w] == pc[31:6]) begin
                hit = 1; way = w[0]; e = me[s][w];
            end
    endfunction
    function automatic longint sat(input longint v, input longint mx);
        return (v >= mx) ? mx : v + 1;
    endfunction
    bit          rh, rw, ih, iw, wh, ww, wdo;
    logic [33:0] re, tmp;
    int          ri, ii, wi;
    always @(posedge clk) begin
        armed = 1;
        if (!rst) begin
            for (int s = 0; s < 16; s++) begin
                mv[s][0] = 0; mv[s][1] = 0; ml[s] = 0;
            end
            lc = 0; hc = 0; lc4 = 0; hc4 = 0;
        end else begin
            ri = int'(bus.read_pc[5:2]);
            ii = int'(bus.inval_pc[5:2]);
            wi = int'(bus.write_pc[5:2]);
            mlook(bus.read_pc, rh, rw, re);
            rh = rh && bus.read_en;
            mlook(bus.inval_pc, ih, iw, tmp);
            ih = ih && bus.inval_en;
            if (ih) mv[ii][iw] = 0;
            wdo = bus.write_en && !(bus.inval_en && bus.inval_pc[31:2] == bus.write_pc[31:2]);
            if (wdo) begin
                mlook(bus.write_pc, wh, ww, tmp);
                if (!wh) ww = !mv[wi][0] ? 1'b0 : !mv[wi][1] ? 1'b1 : ml[wi];
                mv[wi][ww] = 1; mt[wi][ww] = bus.write_pc[31:6]; me[wi][ww] = bus.write_entry;
            end
            if (ih) ml[ii] = iw;
            if (wdo && !(ih && ii == wi)) ml[wi] = !ww;
            if (rh && !(ih && ii == ri) && !(wdo && wi == ri)) ml[ri] = !rw;
            if (bus.read_en) begin lc = sat(lc, 64'hFFFF_FFFF); lc4 = sat(lc4, 15); end
            if (rh) begin hc = sat(hc, 64'hFFFF_FFFF); hc4 = sat(hc4, 15); end
        end
    end
    bit          eh, ew;
    logic [33:0] ee;
    always @(negedge clk) begin
        if (armed) begin
            mlook(bus.read_pc, eh, ew, ee);
            eh = eh && bus.read_en;
            if (!eh) ee = '0;
            chk("cmp read_hit", bus.read_hit, eh);
            chk("cmp read_entry", bus.read_entry, ee);
            chk("cmp lookup_count", bus.lookup_count, lc[31:0]);
            chk("cmp hit_count", bus.hit_count, hc[31:0]);
            chk("cmp4 lookup_count", bus4.lookup_count, lc4[3:0]);
            chk("cmp4 hit_count", bus4.hit_count, hc4[3:0]);
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [31:0] pc, input logic [33:0] e);
        bus.write_en = 1; bus.write_pc = pc; bus.write_entry = e;
        step();
        bus.write_en = 0;
    endtask
    task automatic peek(input string n, input logic [31:0] pc, input bit h, input logic [33:0] e);
        bus.read_en = 1; bus.read_pc = pc;
        #1;
        chk({n, " hit"}, bus.read_hit, h);
        chk({n, " entry"}, bus.read_entry, e);
    endtask
    function automatic logic [31:0] rpc();
        logic [31:0] p;
        p = '0;
        p[7:6] = 2'($urandom_range(0, 3));
        p[3:2] = 2'($urandom_range(0, 3));
        p[1:0] = 2'($urandom_range(0, 3));
        return p;
    endfunction
    initial begin
        bus.read_en = 0; bus.read_pc = '0; bus.write_en = 0; bus.write_pc = '0;
        bus.write_entry = '0; bus.inval_en = 0; bus.inval_pc = '0;
        step(); step();
        rst = 1;
        peek("t1", 32'h60, 0, '0);
        step();
        bus.read_en = 0;
        chk("t1 lookup_count", bus.lookup_count, 1);
        chk("t1 hit_count", bus.hit_count, 0);
        wr(32'h60, {32'h80, JAL});
        peek("t2 0x60", 32'h60, 1, {32'h80, JAL});
        peek("t2 0x62", 32'h62, 1, {32'h80, JAL});
        step();
        bus.read_en = 0;
        wr(32'h000, {32'hA0, BR});
        wr(32'h040, {32'hB0, JAL});
        peek("t3 touch", 32'h000, 1, {32'hA0, BR});
        step();
        bus.read_en = 0;
        wr(32'h080, {32'hC0, JALR});
        peek("t3 evicted", 32'h040, 0, '0);
        peek("t3 keep", 32'h000, 1, {32'hA0, BR});
        peek("t3 new", 32'h080, 1, {32'hC0, JALR});
        step();
        bus.read_en = 0;
        bus.write_en = 1; bus.write_pc = 32'h100; bus.write_entry = {32'hD0, BR};
        bus.inval_en = 1; bus.inval_pc = 32'h100;
        step();
        bus.write_en = 0; bus.inval_en = 0;
        peek("t4 inval wins", 32'h100, 0, '0);
        bus.write_en = 1; bus.write_pc = 32'h104; bus.write_entry = {32'hE0, JAL};
        peek("t4 same cycle", 32'h104, 0, '0);
        step();
        bus.write_en = 0;
        peek("t4 next cycle", 32'h104, 1, {32'hE0, JAL});
        step();
        bus.read_en = 0;
        rst = 0;
        bus.write_en = 1; bus.write_pc = 32'h20; bus.write_entry = {32'h99, BR};
        step();
        rst = 1; bus.write_en = 0;
        peek("t5 reset empty", 32'h60, 0, '0);
        peek("t5 reset drop", 32'h20, 0, '0);
        step();
        bus.read_en = 0;
        wr(32'h20, {32'h40, BR});
        wr(32'h20, {32'h44, JALR});
        peek("t5 update", 32'h20, 1, {32'h44, JALR});
        step();
        bus.read_en = 0;
        wr(32'h60, {32'h90, JAL});
        peek("t5 keep 0x20", 32'h20, 1, {32'h44, JALR});
        peek("t5 other way", 32'h60, 1, {32'h90, JAL});
        step();
        bus.read_en = 0;
        wr(32'hA0, {32'hC4, BR});
        peek("t5 victim", 32'h20, 0, '0);
        peek("t5 survivor", 32'h60, 1, {32'h90, JAL});
        peek("t5 fill", 32'hA0, 1, {32'hC4, BR});
        bus.read_pc = 32'h60;
        repeat (20) step();
        chk("t6 lookup sat", bus4.lookup_count, 4'hF);
        chk("t6 hit sat", bus4.hit_count, 4'hF);
        bus.read_en = 0;
        rst = 0;
        bus.write_en = 1; bus.write_pc = 32'h300; bus.write_entry = {32'h1234, JAL};
        step();
        rst = 1; bus.write_en = 0;
        peek("t6 write dropped", 32'h300, 0, '0);
        peek("t6 array empty", 32'h60, 0, '0);
        chk("t6 counter cleared", bus4.lookup_count, 4'h0);
        step();
        bus.read_en = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) != 0);
            bus.read_en = ($urandom_range(0, 3) != 0);
            bus.read_pc = rpc();
            bus.write_en = ($urandom_range(0, 2) == 0);
            bus.write_pc = rpc();
            bus.write_entry = {$urandom, 2'($urandom_range(0, 3))};
            bus.inval_en = ($urandom_range(0, 4) == 0);
            bus.inval_pc = ($urandom_range(0, 3) == 0) ? bus.write_pc : rpc();
            step();
        end
        rst = 1; bus.read_en = 0; bus.write_en = 0; bus.inval_en = 0;
        step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
